// File: rtl/line_fill_arbiter.sv
// Round-robin arbiter that serialises per-port cache line fills and writebacks
// onto a single word-wide main-memory port, one word per XFER/GAP pair.
module line_fill_arbiter #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned WORDS_PER_LINE = 8,
    parameter int unsigned ADDR_SIZE      = 32
) (
    input  logic                              MEM_CLK,
    input  logic                              RST,
    input  logic [NUM_PORTS-1:0]              REQ,
    input  logic [NUM_PORTS-1:0]              REQ_WE,
    input  logic [NUM_PORTS*ADDR_SIZE-1:0]    REQ_ADDR,
    input  logic [NUM_PORTS*WORD_SIZE-1:0]    WR_DATA,
    output logic [NUM_PORTS-1:0]              GRANT,
    output logic [$clog2(WORDS_PER_LINE)-1:0] WORD_IDX,
    output logic [WORD_SIZE-1:0]              RD_DATA,
    output logic                              RD_VALID,
    output logic [NUM_PORTS-1:0]              DONE,
    output logic                              MM_RE,
    output logic                              MM_WE,
    output logic [ADDR_SIZE-3:0]              MM_ADDR,
    output logic [WORD_SIZE-1:0]              MM_DIN,
    input  logic [WORD_SIZE-1:0]              MM_DOUT,
    input  logic                              MM_VALID
);

    localparam int unsigned IDX_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned MA_W  = ADDR_SIZE - 2;
    localparam int unsigned TAG_W = MA_W - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, XFER, GAP, FIN} state_t;

    state_t               state;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     owner;
    logic [PTR_W-1:0]     winner;
    logic [PTR_W-1:0]     cidx;
    logic [TAG_W-1:0]     line_tag;
    logic                 we_lat;
    logic                 found;
    logic [ADDR_SIZE-1:0] sel_addr;
    int unsigned          cand;
    logic                 unused_addr_bits;

    // Round-robin search starting at ptr, wrapping modulo NUM_PORTS
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        cand   = 0;
        cidx   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = (32'(ptr) + i) % NUM_PORTS;
            cidx = PTR_W'(cand);
            if (!found && REQ[cidx]) begin
                winner = cidx;
                found  = 1'b1;
            end
        end
    end

    assign sel_addr         = REQ_ADDR[32'(winner)*ADDR_SIZE +: ADDR_SIZE];
    assign unused_addr_bits = ^sel_addr[IDX_W+1:0];

    always_ff @(posedge MEM_CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            line_tag <= '0;
            we_lat   <= 1'b0;
            WORD_IDX <= '0;
            GRANT    <= '0;
            DONE     <= '0;
            MM_RE    <= 1'b0;
            MM_WE    <= 1'b0;
            MM_ADDR  <= '0;
        end else begin
            DONE <= '0;
            case (state)
                IDLE: begin
                    GRANT <= '0;
                    if (|REQ) begin
                        owner    <= winner;
                        line_tag <= sel_addr[ADDR_SIZE-1 -: TAG_W];
                        we_lat   <= REQ_WE[winner];
                        WORD_IDX <= '0;
                        GRANT    <= NUM_PORTS'(1) << winner;
                        MM_RE    <= !REQ_WE[winner];
                        MM_WE    <= REQ_WE[winner];
                        MM_ADDR  <= {sel_addr[ADDR_SIZE-1 -: TAG_W], IDX_W'(0)};
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (MM_VALID) begin
                        MM_RE <= 1'b0;
                        MM_WE <= 1'b0;
                        if (WORD_IDX == LAST_IDX) begin
                            DONE  <= GRANT;
                            state <= FIN;
                        end else begin
                            WORD_IDX <= WORD_IDX + IDX_W'(1);
                            state    <= GAP;
                        end
                    end
                end
                GAP: begin
                    MM_RE   <= !we_lat;
                    MM_WE   <= we_lat;
                    MM_ADDR <= {line_tag, WORD_IDX};
                    state   <= XFER;
                end
                FIN: begin
                    GRANT    <= '0;
                    WORD_IDX <= '0;
                    ptr      <= (32'(owner) == NUM_PORTS - 1) ? '0 : owner + PTR_W'(1);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data paths follow same-cycle memory/requestor inputs during XFER only
    always_comb begin
        MM_DIN   = '0;
        RD_VALID = 1'b0;
        RD_DATA  = '0;
        if (state == XFER) begin
            if (we_lat) begin
                MM_DIN = WR_DATA[32'(owner)*WORD_SIZE +: WORD_SIZE];
            end else if (MM_VALID) begin
                RD_VALID = 1'b1;
                RD_DATA  = MM_DOUT;
            end
        end
    end

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Randomised bench for line_fill_arbiter against a transaction-level model of
// arbitration order and per-word memory handshakes.
module tb_line_fill_arbiter;

    localparam int unsigned NP  = 4;
    localparam int unsigned WS  = 32;
    localparam int unsigned WPL = 8;
    localparam int unsigned AS  = 32;
    localparam int unsigned IW  = 3;
    localparam int unsigned MA  = AS - 2;

    logic            MEM_CLK = 1'b0;
    logic            RST;
    logic [NP-1:0]   REQ, REQ_WE, GRANT, DONE;
    logic [NP*AS-1:0] REQ_ADDR;
    logic [NP*WS-1:0] WR_DATA;
    logic [IW-1:0]   WORD_IDX;
    logic [WS-1:0]   RD_DATA, MM_DIN, MM_DOUT;
    logic            RD_VALID, MM_RE, MM_WE, MM_VALID;
    logic [MA-1:0]   MM_ADDR;

    int total = 0;
    int bad   = 0;

    line_fill_arbiter #(.NUM_PORTS(NP), .WORD_SIZE(WS), .WORDS_PER_LINE(WPL), .ADDR_SIZE(AS)) dut (
        .MEM_CLK(MEM_CLK), .RST(RST), .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
        .WR_DATA(WR_DATA), .GRANT(GRANT), .WORD_IDX(WORD_IDX), .RD_DATA(RD_DATA),
        .RD_VALID(RD_VALID), .DONE(DONE), .MM_RE(MM_RE), .MM_WE(MM_WE), .MM_ADDR(MM_ADDR),
        .MM_DIN(MM_DIN), .MM_DOUT(MM_DOUT), .MM_VALID(MM_VALID));

    always #5 MEM_CLK = ~MEM_CLK;

    function automatic logic [31:0] wr_word(input int p, input int k);
        return 32'(p) * 32'h100 + 32'hA0 + 32'(k);
    endfunction

    function automatic logic [31:0] mem_word(input logic [MA-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00C3;
    endfunction

    // Requestors present the writeback word for whatever index is in flight
    always_comb begin
        WR_DATA = '0;
        for (int p = 0; p < NP; p++) WR_DATA[p*WS +: WS] = wr_word(p, int'(WORD_IDX));
    end

    // Requestor-side state
    bit          active[NP];
    bit          dropped[NP];
    logic [31:0] addr_q[NP];
    bit          we_q[NP];

    // Reference model
    bit            m_busy, m_post, m_we;
    int            m_owner, m_k, m_ptr, m_done_cnt;
    logic [MA-1:0] m_line;
    bit            hs_next, prev_exp_strobe;
    int            stall, stall_cfg;
    bit            noise_en, auto_en, all_req;

    // Observed history
    int            cyc, last_done_cyc, rd_seen;
    logic [NP-1:0] prev_grant_obs;
    int            grant_log[$];
    int            gap_log[$];
    logic [MA-1:0] first_addr;
    int            done_obs[NP];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_ports();
        for (int p = 0; p < NP; p++) begin
            REQ[p]              = active[p] && !dropped[p];
            REQ_WE[p]           = we_q[p];
            REQ_ADDR[p*AS +: AS] = addr_q[p];
        end
    endtask

    task automatic raise(input int p, input logic [31:0] a, input bit we);
        active[p]  = 1'b1;
        dropped[p] = 1'b0;
        addr_q[p]  = a;
        we_q[p]    = we;
    endtask

    task automatic check_rst_outs(input string tag);
        check({tag, "_grant"}, 64'(GRANT), 64'(0));
        check({tag, "_done"}, 64'(DONE), 64'(0));
        check({tag, "_rdv"}, 64'(RD_VALID), 64'(0));
        check({tag, "_re"}, 64'(MM_RE), 64'(0));
        check({tag, "_we"}, 64'(MM_WE), 64'(0));
        check({tag, "_addr"}, 64'(MM_ADDR), 64'(0));
        check({tag, "_din"}, 64'(MM_DIN), 64'(0));
        check({tag, "_rdd"}, 64'(RD_DATA), 64'(0));
        check({tag, "_idx"}, 64'(WORD_IDX), 64'(0));
    endtask

    task automatic apply_reset(input bit chk_now, input int n);
        RST      = 1'b1;
        MM_VALID = 1'b1;
        hs_next  = 1'b0;
        if (chk_now) begin
            #1;
            check_rst_outs("rst_async");
        end
        repeat (n) begin
            @(posedge MEM_CLK); #1;
            cyc++;
            check_rst_outs("rst_hold");
        end
        m_busy = 0; m_post = 0; m_ptr = 0;
        prev_exp_strobe = 0; stall = 0; prev_grant_obs = '0;
        MM_VALID = 1'b0;
        RST      = 1'b0;
    endtask

    task automatic cycle_step();
        logic [NP-1:0] req_s, exp_g, exp_done;
        logic [31:0]   a;
        bit            hs, exp_strobe;
        @(posedge MEM_CLK); #1;
        cyc++;
        req_s = REQ;
        hs = hs_next;
        exp_g = '0; exp_done = '0; exp_strobe = 0;
        if (hs) m_k++;
        if (m_busy) begin
            exp_g = NP'(1) << m_owner;
            if (hs && m_k == WPL) begin
                exp_done = exp_g;
                m_busy = 0; m_post = 1;
                m_ptr = (m_owner + 1) % NP;
                m_done_cnt++;
            end else begin
                exp_strobe = !hs;
            end
        end else if (m_post) begin
            m_post = 0;
        end else if (req_s != '0) begin
            for (int i = 0; i < NP; i++) begin
                int c;
                c = (m_ptr + i) % NP;
                if (!m_busy && req_s[c]) begin m_owner = c; m_busy = 1; end
            end
            a = REQ_ADDR[m_owner*AS +: AS];
            m_we = REQ_WE[m_owner];
            m_line = a[AS-1:2] & ~MA'(WPL - 1);
            m_k = 0;
            exp_g = NP'(1) << m_owner;
            exp_strobe = 1;
        end

        check("grant", 64'(GRANT), 64'(exp_g));
        check("done", 64'(DONE), 64'(exp_done));
        check("mm_re", 64'(MM_RE), 64'(exp_strobe && !m_we));
        check("mm_we", 64'(MM_WE), 64'(exp_strobe && m_we));
        if (exp_strobe) begin
            check("mm_addr", 64'(MM_ADDR), 64'(m_line + MA'(m_k)));
            check("word_idx", 64'(WORD_IDX), 64'(m_k));
        end

        if (GRANT != '0 && prev_grant_obs == '0) begin
            for (int p = 0; p < NP; p++) if (GRANT[p]) grant_log.push_back(p);
            gap_log.push_back(cyc - last_done_cyc);
            first_addr = MM_ADDR;
        end
        if (DONE != '0) begin
            last_done_cyc = cyc;
            for (int p = 0; p < NP; p++) if (DONE[p]) done_obs[p]++;
        end
        prev_grant_obs = GRANT;

        if (exp_strobe) begin
            if (!prev_exp_strobe) stall = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
            if (stall == 0) begin
                MM_VALID = 1'b1;
                MM_DOUT  = mem_word(m_line + MA'(m_k));
            end else begin
                stall--;
                MM_VALID = 1'b0;
                MM_DOUT  = $urandom;
            end
        end else begin
            MM_VALID = noise_en && ($urandom_range(0, 3) == 0);
            MM_DOUT  = $urandom;
        end
        prev_exp_strobe = exp_strobe;
        hs_next = exp_strobe && MM_VALID;

        if (exp_done != '0) begin
            active[m_owner]  = 1'b0;
            dropped[m_owner] = 1'b0;
        end
        for (int p = 0; p < NP; p++) begin
            if (!active[p]) begin
                if (all_req || (auto_en && $urandom_range(0, 3) == 0)) raise(p, $urandom, 1'($urandom_range(0, 1)));
            end else if (auto_en && m_busy && m_owner == p) begin
                if ($urandom_range(0, 7) == 0) addr_q[p] = $urandom;
                if ($urandom_range(0, 7) == 0) we_q[p] = !we_q[p];
                if ($urandom_range(0, 7) == 0) dropped[p] = 1'b1;
            end
        end
        drive_ports();

        #2;
        check("rd_valid", 64'(RD_VALID), 64'(hs_next && !m_we));
        if (RD_VALID) rd_seen++;
        if (hs_next && !m_we) check("rd_data", 64'(RD_DATA), 64'(mem_word(m_line + MA'(m_k))));
        if (exp_strobe && m_we) check("mm_din", 64'(MM_DIN), 64'(wr_word(m_owner, m_k)));
    endtask

    task automatic run_txns(input int n, input int budget);
        int target;
        int c;
        target = m_done_cnt + n;
        c = 0;
        while (m_done_cnt < target && c < budget) begin
            cycle_step();
            c++;
        end
    endtask

    task automatic clear_ports();
        for (int p = 0; p < NP; p++) begin active[p] = 0; dropped[p] = 0; addr_q[p] = '0; we_q[p] = 0; end
        drive_ports();
    endtask

    initial begin
        int d0, c, any;
        RST = 1'b1; MM_VALID = 1'b0; MM_DOUT = '0;
        stall_cfg = -1; noise_en = 0; auto_en = 0; all_req = 0;
        cyc = 0; last_done_cyc = 0; m_done_cnt = 0; rd_seen = 0;
        for (int p = 0; p < NP; p++) done_obs[p] = 0;
        clear_ports();
        apply_reset(1'b0, 3);

        // Single fill from port 0, memory answers one cycle after each strobe
        stall_cfg = 1; rd_seen = 0; d0 = done_obs[0];
        raise(0, 32'h0000_6024, 1'b0); drive_ports();
        run_txns(1, 100);
        check("fill_first_addr", 64'(first_addr), 64'(30'h1808));
        check("fill_rd_count", 64'(rd_seen), 64'(8));
        check("fill_done0", 64'(done_obs[0] - d0), 64'(1));

        // Writeback from port 1 with random latency and stray MM_VALID noise
        stall_cfg = -1; noise_en = 1; rd_seen = 0;
        raise(1, 32'h0000_7000, 1'b1); drive_ports();
        run_txns(1, 200);
        check("wb_first_addr", 64'(first_addr), 64'(30'h1C00));
        check("wb_rd_count", 64'(rd_seen), 64'(0));

        // Simultaneous requests after reset: port 0 then port 1, two cycles apart
        apply_reset(1'b0, 2);
        grant_log.delete(); gap_log.delete();
        raise(0, $urandom, 1'b0); raise(1, $urandom, 1'b1); drive_ports();
        run_txns(2, 300);
        check("sim_count", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() >= 2) begin
            check("sim_first", 64'(grant_log[0]), 64'(0));
            check("sim_second", 64'(grant_log[1]), 64'(1));
            check("sim_gap", 64'(gap_log[1]), 64'(2));
        end

        // All four ports held high: strict rotation
        apply_reset(1'b0, 2);
        grant_log.delete();
        all_req = 1;
        for (int p = 0; p < NP; p++) raise(p, $urandom, 1'($urandom_range(0, 1)));
        drive_ports();
        run_txns(8, 800);
        all_req = 0;
        check("rr_count", 64'(grant_log.size()), 64'(8));
        for (int i = 0; i < grant_log.size() && i < 8; i++) check("rr_order", 64'(grant_log[i]), 64'(i % 4));

        // Reset while port 1 is mid-burst at word 3
        apply_reset(1'b0, 2);
        clear_ports();
        raise(1, $urandom, 1'b0); drive_ports();
        c = 0;
        while (!(m_busy && m_k == 3 && prev_exp_strobe) && c < 200) begin cycle_step(); c++; end
        check("mid_reach_idx3", 64'(WORD_IDX), 64'(3));
        raise(2, $urandom, 1'b1); raise(3, $urandom, 1'b0); drive_ports();
        #1;
        apply_reset(1'b1, 2);
        grant_log.delete();
        run_txns(1, 200);
        check("mid_regrant_count", 64'(grant_log.size() > 0), 64'(1));
        if (grant_log.size() > 0) check("mid_regrant_port", 64'(grant_log[0]), 64'(1));

        // Port 2 drops REQ and scrambles its address after grant, memory stalls 5 cycles per word
        clear_ports();
        run_txns(4, 600);
        clear_ports();
        c = 0;
        while ((m_busy || m_post) && c < 300) begin cycle_step(); c++; end
        stall_cfg = 5; d0 = done_obs[2];
        raise(2, 32'h0001_2340, 1'b0); drive_ports();
        c = 0;
        while (!m_busy && c < 10) begin cycle_step(); c++; end
        dropped[2] = 1'b1; addr_q[2] = 32'hFFFF_FFFF; we_q[2] = 1'b1; drive_ports();
        run_txns(1, 300);
        check("drop_done2", 64'(done_obs[2] - d0), 64'(1));

        // Random traffic with random latency, drops and address churn
        stall_cfg = -1; auto_en = 1;
        repeat (1500) cycle_step();
        auto_en = 0;
        c = 0;
        any = 1;
        while (any != 0 && c < 3000) begin
            cycle_step();
            c++;
            any = (m_busy || m_post) ? 1 : 0;
            for (int p = 0; p < NP; p++) if (active[p]) any = 1;
        end
        check("drain_idle_grant", 64'(GRANT), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
